lkt_lookup_responder: RTL and testbench
=======================================

// Module: lkt_lookup_responder
// PURPOSE
//  DUT-side responder of the lkt lookup protocol: accepts a request carrying
//  NUM_LOOKUPS choice indices and returns NUM_LOOKUPS results of RESULT_WIDTH.
//  Results come from a programmable NUM_CHOICES-entry table. Lanes are resolved
//  serially, one per cycle, by a small FSM. The packed response is held until
//  the consumer accepts it.
// PARAMETERS
//  RESULT_WIDTH  32  width of one table entry / one lane result
//  NUM_LOOKUPS    4  lanes per request (>=1)
//  NUM_CHOICES    8  table entries (>=2); SEL_W = $clog2(NUM_CHOICES)
// PORTS
//  clk          in   1                         clock, all logic on rising edge
//  rst_n        in   1                         async active-low reset
//  cfg_wr_en    in   1                         write table entry
//  cfg_wr_idx   in   SEL_W                     entry index to write
//  cfg_wr_data  in   RESULT_WIDTH              entry value
//  cfg_clr      in   1                         invalidate all entries
//  req_valid    in   1                         request valid
//  req_ready    out  1                         responder can accept request
//  req_sel      in   NUM_LOOKUPS*SEL_W         lane i index at [i*SEL_W +: SEL_W]
//  rsp_valid    out  1                         response valid
//  rsp_ready    in   1                         consumer accepts response
//  rsp_result   out  NUM_LOOKUPS*RESULT_WIDTH  lane i result at [i*RW +: RW]
//  rsp_hit      out  NUM_LOOKUPS               lane i index valid and entry written
//  rsp_err      out  1                         some lane index >= NUM_CHOICES
// BEHAVIOUR
//  Reset (async assert, sync deassert at the clk edge): state=IDLE, all table
//   entries and valid bits =0, rsp_valid=0, rsp_result=0, rsp_hit=0, rsp_err=0.
//   req_ready=0 while rst_n=0 and =1 from the first clk edge after release.
//   Reset in mid-request drops the request and gives no response.
//  FSM: IDLE -> LOOKUP on req_valid&&req_ready; req_sel is captured into a register.
//   LOOKUP: lane counter runs 0..NUM_LOOKUPS-1, one lane per cycle. It then
//   goes to RESP. RESP -> IDLE on rsp_valid&&rsp_ready.
//  req_ready=1 only in IDLE (registered decode of the state, no combinational path
//   from rsp_ready). rsp_valid=1 only in RESP.
//  Latency: request accepted at edge T; lanes resolved at edges T+1..T+NUM_LOOKUPS.
//   rsp_valid is high after edge T+NUM_LOOKUPS. Next req_ready comes one edge after
//   the response handshake. Minimum period = NUM_LOOKUPS+2 cycles.
//  Lane resolve: idx<NUM_CHOICES and valid[idx] -> result=table[idx], hit=1.
//   idx<NUM_CHOICES and not valid -> result=0, hit=0.
//   idx>=NUM_CHOICES -> result=0, hit=0, err sticky-set for this request.
//  rsp_result, rsp_hit and rsp_err are cleared on request accept. They are stable
//   throughout RESP, with any rsp_ready backpressure length.
//  Table write: table[idx]<=data, valid[idx]<=1 at the edge. idx>=NUM_CHOICES is
//   ignored. cfg_clr clears all valid bits and has priority over a write in the
//   same cycle; data bits are not cleared.
//  Write/read collision: a lane reading the index written in the same cycle sees the
//   old value and old valid. Writes and clears are legal in every state. Lanes
//   resolved later see the update; lanes already resolved keep their results.
//  req_sel changes after acceptance have no effect. req_valid in non-IDLE is ignored.
// TESTING (NUM_LOOKUPS=4, NUM_CHOICES=6, RESULT_WIDTH=32)
//  1 Reset: rst_n=0 mid-LOOKUP -> rsp_valid=0 and outputs 0 at once. After release,
//    req_ready=1 and a read of any entry gives hit=0.
//  2 Write e[i]=0xA0+i for i=0..5; request sel={5,0,3,1} (lane3..0). At T+4,
//    rsp_valid=1, result lanes0..3 = {A1,A3,A0,A5}, hit=4'hF, err=0.
//  3 Invalid index: sel={7,6,2,2} with e2 written -> lanes0,1=0xA2, lanes2,3=0,
//    hit=4'b0011, err=1. Entry 6 write is ignored.
//  4 Backpressure: rsp_ready=0 for 10 cycles -> outputs stable and req_ready=0. The
//    handshake gives req_ready=1 on the next cycle. Back-to-back requests are 6
//    cycles apart.
//  5 Collision: write e3=0x55 at edge T+1 while lane0 reads idx3 (old 0xA3) and
//    lane1 reads idx3 -> lane0=0xA3, lane1=0x55.
//  6 cfg_clr with cfg_wr_en(idx0) in the same cycle -> all hit=0 afterwards, including
//    idx0. A later write of idx0 restores hit.

Source files
------------

// File: rtl/lkt_lookup_responder.sv
// Lookup responder: accepts NUM_LOOKUPS table indices per request, resolves one
// lane per cycle from a programmable table, and holds the packed response until accepted.
module lkt_lookup_responder #(
  parameter int RESULT_WIDTH = 32,
  parameter int NUM_LOOKUPS  = 4,
  parameter int NUM_CHOICES  = 8,
  localparam int SEL_W       = $clog2(NUM_CHOICES)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cfg_wr_en,
  input  logic [SEL_W-1:0]                  cfg_wr_idx,
  input  logic [RESULT_WIDTH-1:0]           cfg_wr_data,
  input  logic                              cfg_clr,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [NUM_LOOKUPS*SEL_W-1:0]      req_sel,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [NUM_LOOKUPS*RESULT_WIDTH-1:0] rsp_result,
  output logic [NUM_LOOKUPS-1:0]            rsp_hit,
  output logic                              rsp_err
);

  // state  | meaning
  // IDLE   | waiting for a request, req_ready high
  // LOOKUP | resolving lane lane_q this cycle
  // RESP   | response presented until rsp_ready

  localparam int LANE_W = (NUM_LOOKUPS > 1) ? $clog2(NUM_LOOKUPS) : 1;
  localparam int SEL_N  = 2 ** SEL_W;

  // Index-space mask: bit i set when index i addresses a real entry.
  function automatic logic [SEL_N-1:0] range_mask();
    logic [SEL_N-1:0] m;
    for (int i = 0; i < SEL_N; i++) m[i] = (i < NUM_CHOICES);
    return m;
  endfunction

  localparam logic [SEL_N-1:0] IN_RANGE = range_mask();

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESP} state_e;

  state_e                              state_q, state_d;
  logic                                req_ready_q, req_ready_d;
  logic [NUM_LOOKUPS*SEL_W-1:0]        sel_q;
  logic [LANE_W-1:0]                   lane_q;
  logic [NUM_LOOKUPS*RESULT_WIDTH-1:0] res_q;
  logic [NUM_LOOKUPS-1:0]              hit_q;
  logic                                err_q;
  logic [RESULT_WIDTH-1:0]             tbl_q [NUM_CHOICES];
  logic [NUM_CHOICES-1:0]              valid_q;

  logic                                accept;
  logic                                last_lane;
  logic [SEL_W-1:0]                    lane_idx;
  logic                                rd_ok;
  logic                                rd_valid;
  logic [RESULT_WIDTH-1:0]             rd_data;
  logic                                rd_hit;

  assign accept    = (state_q == S_IDLE) && req_valid && req_ready_q;
  assign last_lane = (lane_q == LANE_W'(NUM_LOOKUPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_LOOKUP;
      S_LOOKUP: if (last_lane) state_d = S_RESP;
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // req_ready is a flop decoded from the next state, so rsp_ready never reaches it combinationally.
  always_comb begin
    req_ready_d = (state_d == S_IDLE);
    rsp_valid   = (state_q == S_RESP);
  end

  assign req_ready  = req_ready_q;
  assign rsp_result = res_q;
  assign rsp_hit    = hit_q;
  assign rsp_err    = err_q;

  always_comb begin
    lane_idx = '0;
    for (int l = 0; l < NUM_LOOKUPS; l++) begin
      if (lane_q == LANE_W'(l)) lane_idx = sel_q[l*SEL_W +: SEL_W];
    end
  end

  always_comb begin
    rd_valid = 1'b0;
    rd_data  = '0;
    for (int i = 0; i < NUM_CHOICES; i++) begin
      if (lane_idx == SEL_W'(i)) begin
        rd_valid = valid_q[i];
        rd_data  = tbl_q[i];
      end
    end
  end

  assign rd_ok  = IN_RANGE[lane_idx];
  assign rd_hit = rd_ok && rd_valid;

  // Table reads above see pre-edge contents, giving old-value semantics on a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_CHOICES; i++) tbl_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CHOICES; i++) begin
        if (cfg_clr) begin
          valid_q[i] <= 1'b0;
        end else if (cfg_wr_en && (cfg_wr_idx == SEL_W'(i))) begin
          valid_q[i] <= 1'b1;
          tbl_q[i]   <= cfg_wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      lane_q <= '0;
      res_q  <= '0;
      hit_q  <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      sel_q  <= req_sel;
      lane_q <= '0;
      res_q  <= '0;
      hit_q  <= '0;
      err_q  <= 1'b0;
    end else if (state_q == S_LOOKUP) begin
      for (int l = 0; l < NUM_LOOKUPS; l++) begin
        if (lane_q == LANE_W'(l)) begin
          res_q[l*RESULT_WIDTH +: RESULT_WIDTH] <= rd_hit ? rd_data : '0;
          hit_q[l] <= rd_hit;
        end
      end
      err_q  <= err_q | ~rd_ok;
      lane_q <= lane_q + LANE_W'(1);
    end
  end

endmodule

// File: tb/tb_lkt_lookup_responder.sv
// Scoreboard bench for lkt_lookup_responder: directed cases plus randomized
// requests with table writes interleaved with lane resolution.
module tb_lkt_lookup_responder;
  localparam int RW = 32;
  localparam int NL = 4;
  localparam int NC = 6;
  localparam int SW = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_wr_en = 1'b0;
  logic [SW-1:0]  cfg_wr_idx = '0;
  logic [RW-1:0]  cfg_wr_data = '0;
  logic           cfg_clr = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [NL*SW-1:0] req_sel = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [NL*RW-1:0] rsp_result;
  logic [NL-1:0]  rsp_hit;
  logic           rsp_err;

  lkt_lookup_responder #(.RESULT_WIDTH(RW), .NUM_LOOKUPS(NL), .NUM_CHOICES(NC)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx), .cfg_wr_data(cfg_wr_data), .cfg_clr(cfg_clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_hit(rsp_hit), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NL*RW-1:0] res;
    logic [NL-1:0]    hit;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_accept = 0;

  logic [RW-1:0] mtbl [NC];
  logic          mval [NC];

  logic          sch_en  [NL];
  logic          sch_clr [NL];
  logic [SW-1:0] sch_idx [NL];
  logic [RW-1:0] sch_dat [NL];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [NL*RW-1:0] act, input logic [NL*RW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", rsp_valid, 0);
      end else begin
        chk("rsp_result", rsp_result, exp_q[0].res);
        chk("rsp_hit", rsp_hit, exp_q[0].hit);
        chk("rsp_err", rsp_err, exp_q[0].err);
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      mtbl[i] = '0;
      mval[i] = 1'b0;
    end
  endtask

  task automatic clr_sched();
    for (int l = 0; l < NL; l++) begin
      sch_en[l] = 1'b0; sch_clr[l] = 1'b0; sch_idx[l] = '0; sch_dat[l] = '0;
    end
  endtask

  // Apply one config operation to the reference table.
  task automatic model_op(input logic en, input logic clr, input logic [SW-1:0] idx, input logic [RW-1:0] d);
    if (clr) begin
      for (int i = 0; i < NC; i++) mval[i] = 1'b0;
    end else if (en && int'(idx) < NC) begin
      mtbl[int'(idx)] = d;
      mval[int'(idx)] = 1'b1;
    end
  endtask

  task automatic cfg(input logic en, input logic clr, input logic [SW-1:0] idx, input logic [RW-1:0] d);
    cfg_wr_en = en; cfg_clr = clr; cfg_wr_idx = idx; cfg_wr_data = d;
    @(posedge clk); #1;
    cfg_wr_en = 1'b0; cfg_clr = 1'b0;
    model_op(en, clr, idx, d);
  endtask

  // Lane l reads the table as it stands before the edge that also applies schedule op l.
  task automatic do_req(input logic [NL*SW-1:0] sel, input int bp);
    exp_t e;
    int n;
    int idx;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) chk("req_ready_timeout", req_ready, 1);
    e.res = '0; e.hit = '0; e.err = 1'b0;
    for (int l = 0; l < NL; l++) begin
      idx = int'(sel[l*SW +: SW]);
      if (idx >= NC) e.err = 1'b1;
      else if (mval[idx]) begin
        e.res[l*RW +: RW] = mtbl[idx];
        e.hit[l] = 1'b1;
      end
      model_op(sch_en[l], sch_clr[l], sch_idx[l], sch_dat[l]);
    end
    exp_q.push_back(e);
    req_valid = 1'b1; req_sel = sel;
    @(posedge clk); #1;
    chk("accept_spacing_valid", (cyc - last_accept) >= 6, 1);
    last_accept = cyc;
    req_valid = 1'b0; req_sel = NL*SW'($urandom);
    for (int l = 0; l < NL; l++) begin
      cfg_wr_en = sch_en[l]; cfg_clr = sch_clr[l]; cfg_wr_idx = sch_idx[l]; cfg_wr_data = sch_dat[l];
      @(posedge clk); #1;
      cfg_wr_en = 1'b0; cfg_clr = 1'b0;
      chk("rsp_valid_latency", rsp_valid, (l == NL - 1));
      chk("req_ready_busy", req_ready, 0);
    end
    for (int b = 0; b < bp; b++) begin
      @(posedge clk); #1;
      chk("req_ready_bp", req_ready, 0);
      chk("rsp_valid_bp", rsp_valid, 1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("req_ready_after_hs", req_ready, 1);
    chk("rsp_valid_after_hs", rsp_valid, 0);
    clr_sched();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NL*SW-1:0] s;
    int a0;
    clr_sched();
    model_reset();
    #12;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_result", rsp_result, 0);
    chk("reset_hit", rsp_hit, 0);
    chk("reset_err", rsp_err, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", req_ready, 1);

    // Writes and a full-hit request.
    for (int i = 0; i < NC; i++) cfg(1'b1, 1'b0, SW'(i), RW'(32'hA0 + i));
    do_req({3'd5, 3'd0, 3'd3, 3'd1}, 0);
    chk("model_lane_check", {mtbl[1], mtbl[3]}, {32'hA1, 32'hA3});

    // Out-of-range indices and ignored write to entry 6.
    cfg(1'b1, 1'b0, 3'd6, 32'hDEAD);
    do_req({3'd7, 3'd6, 3'd2, 3'd2}, 0);

    // Backpressure, then two back-to-back requests.
    do_req({3'd4, 3'd3, 3'd2, 3'd1}, 10);
    do_req({3'd0, 3'd1, 3'd2, 3'd3}, 0);
    a0 = last_accept;
    do_req({3'd5, 3'd4, 3'd3, 3'd2}, 0);
    chk("back_to_back_period", last_accept - a0, 6);

    // Same-cycle write while lane0 reads the written index.
    sch_en[0] = 1'b1; sch_idx[0] = 3'd3; sch_dat[0] = 32'h55;
    do_req({3'd0, 3'd1, 3'd3, 3'd3}, 2);

    // Clear beats a simultaneous write; a later write restores the hit.
    cfg(1'b1, 1'b1, 3'd0, 32'h77);
    do_req({3'd3, 3'd2, 3'd1, 3'd0}, 0);
    cfg(1'b1, 1'b0, 3'd0, 32'h99);
    do_req({3'd3, 3'd2, 3'd1, 3'd0}, 1);

    // Randomized requests with interleaved config traffic.
    for (int r = 0; r < 30; r++) begin
      for (int l = 0; l < NL; l++) begin
        sch_en[l]  = ($urandom_range(0, 2) == 0);
        sch_clr[l] = ($urandom_range(0, 15) == 0);
        sch_idx[l] = SW'($urandom_range(0, 7));
        sch_dat[l] = $urandom;
      end
      if ($urandom_range(0, 3) == 0) cfg(1'b1, 1'b0, SW'($urandom_range(0, 5)), $urandom);
      s = NL*SW'($urandom);
      do_req(s, $urandom_range(0, 3));
    end

    // Reset in the middle of LOOKUP drops the request.
    req_valid = 1'b1; req_sel = {3'd0, 3'd1, 3'd2, 3'd3};
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_rsp_valid", rsp_valid, 0);
    chk("midreset_result", rsp_result, 0);
    chk("midreset_hit", rsp_hit, 0);
    chk("midreset_err", rsp_err, 0);
    chk("midreset_req_ready", req_ready, 0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_midreset", req_ready, 1);
    last_accept = 0;
    do_req({3'd5, 3'd4, 3'd1, 3'd0}, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
